// File: rtl/ex_stage_pkg.sv
// Shared widths, opcode/funct constants and divider state encodings for the
// RV32IM execute stage.
package ex_stage_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned AluOpBus     = 7;
  localparam int unsigned AluFunct3Bus = 3;
  localparam int unsigned AluFunct7Bus = 7;
  localparam int unsigned DivCntBus    = 5;

  localparam logic [AluOpBus-1:0] EXE_R_TYPE_OP = 7'b0110011;
  localparam logic [AluOpBus-1:0] EXE_I_TYPE_OP = 7'b0010011;

  // Base integer funct3
  localparam logic [AluFunct3Bus-1:0] F3_ADD  = 3'b000;
  localparam logic [AluFunct3Bus-1:0] F3_SLL  = 3'b001;
  localparam logic [AluFunct3Bus-1:0] F3_SLT  = 3'b010;
  localparam logic [AluFunct3Bus-1:0] F3_SLTU = 3'b011;
  localparam logic [AluFunct3Bus-1:0] F3_XOR  = 3'b100;
  localparam logic [AluFunct3Bus-1:0] F3_SR   = 3'b101;
  localparam logic [AluFunct3Bus-1:0] F3_OR   = 3'b110;
  localparam logic [AluFunct3Bus-1:0] F3_AND  = 3'b111;

  // M extension funct3
  localparam logic [AluFunct3Bus-1:0] F3_MUL    = 3'b000;
  localparam logic [AluFunct3Bus-1:0] F3_MULH   = 3'b001;
  localparam logic [AluFunct3Bus-1:0] F3_MULHSU = 3'b010;
  localparam logic [AluFunct3Bus-1:0] F3_MULHU  = 3'b011;
  localparam logic [AluFunct3Bus-1:0] F3_DIV    = 3'b100;
  localparam logic [AluFunct3Bus-1:0] F3_DIVU   = 3'b101;
  localparam logic [AluFunct3Bus-1:0] F3_REM    = 3'b110;
  localparam logic [AluFunct3Bus-1:0] F3_REMU   = 3'b111;

  localparam logic [AluFunct7Bus-1:0] F7_BASE   = 7'b0000000;
  localparam logic [AluFunct7Bus-1:0] F7_ALT    = 7'b0100000;
  localparam logic [AluFunct7Bus-1:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic                  wd;
    logic [RegAddrBus-1:0] wreg;
    logic [RegBus-1:0]     wdata;
  } ex_wb_t;

  // DIV/DIVU/REM/REMU all share funct7 MULDIV with funct3[2] set
  function automatic logic is_div_op(input logic [AluOpBus-1:0]     op,
                                     input logic [AluFunct3Bus-1:0] f3,
                                     input logic [AluFunct7Bus-1:0] f7);
    return (op == EXE_R_TYPE_OP) && (f7 == F7_MULDIV) && f3[2];
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on
// magnitudes, with sign correction and div-by-zero/overflow shortcuts.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              rem_op,
  input  logic [RegBus-1:0] dividend,
  input  logic [RegBus-1:0] divisor,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [RegBus-1:0] result
);

  div_state_t           state;
  logic [DivCntBus-1:0] cnt;
  logic [RegBus-1:0]    quot;
  logic [RegBus-1:0]    rem;
  logic [RegBus-1:0]    divr;
  logic                 neg_q;
  logic                 neg_r;
  logic                 sel_rem;

  logic                 div_zero;
  logic                 overflow;
  logic [RegBus-1:0]    abs_dvd;
  logic [RegBus-1:0]    abs_dvs;
  logic [RegBus:0]      rem_shift;
  logic [RegBus:0]      diff;

  assign div_zero  = (divisor == '0);
  assign overflow  = signed_op && (dividend == 32'h8000_0000) && (divisor == '1);
  assign abs_dvd   = (signed_op && dividend[RegBus-1]) ? -dividend : dividend;
  assign abs_dvs   = (signed_op && divisor[RegBus-1])  ? -divisor  : divisor;

  // Shift next dividend bit into the partial remainder, then trial-subtract
  assign rem_shift = {rem, quot[RegBus-1]};
  assign diff      = rem_shift - {1'b0, divr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      quot    <= '0;
      rem     <= '0;
      divr    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            sel_rem <= rem_op;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            // Special results are parked in quot/rem so DONE needs no extra path
            if (div_zero) begin
              quot  <= '1;
              rem   <= dividend;
              state <= DIV_DONE;
            end else if (overflow) begin
              quot  <= 32'h8000_0000;
              rem   <= '0;
              state <= DIV_DONE;
            end else begin
              quot  <= abs_dvd;
              rem   <= '0;
              divr  <= abs_dvs;
              neg_q <= signed_op && (dividend[RegBus-1] ^ divisor[RegBus-1]);
              neg_r <= signed_op && dividend[RegBus-1];
              state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          quot <= {quot[RegBus-2:0], ~diff[RegBus]};
          rem  <= diff[RegBus] ? rem_shift[RegBus-1:0] : diff[RegBus-1:0];
          cnt  <= cnt + DivCntBus'(1);
          if (cnt == '1) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy   = !flush && (((state == DIV_IDLE) && start) || (state == DIV_CALC));
  assign done   = !flush && (state == DIV_DONE);
  assign result = sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU and multiplier, iterative divider
// that stalls the front of the pipeline while it runs.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AluOpBus-1:0]     aluop_i,
  input  logic [AluFunct3Bus-1:0] alufunct3_i,
  input  logic [AluFunct7Bus-1:0] alufunct7_i,
  input  logic [RegBus-1:0]       reg1_i,
  input  logic [RegBus-1:0]       reg2_i,
  input  logic [RegAddrBus-1:0]   wreg_i,
  input  logic                    wd_i,
  input  logic                    flush,
  output logic                    wd_o,
  output logic [RegAddrBus-1:0]   wreg_o,
  output logic [RegBus-1:0]       wdata_o,
  output logic                    stallreq
);

  localparam int unsigned ProdW = 2 * RegBus + 2;

  logic                    r_type;
  logic                    i_type;
  logic                    base_op;
  logic                    mul_op;
  logic                    div_op;
  logic                    is_sub;
  logic [4:0]              shamt;
  logic                    slt_res;
  logic [RegBus-1:0]       sra_res;
  logic [RegBus-1:0]       alu_res;

  logic                    a_signed;
  logic                    b_signed;
  logic signed [RegBus:0]  mul_a;
  logic signed [RegBus:0]  mul_b;
  logic signed [ProdW-1:0] prod;
  logic                    unused_prod;

  logic                    div_busy;
  logic                    div_done;
  logic [RegBus-1:0]       div_result;
  ex_wb_t                  wb;

  assign r_type  = (aluop_i == EXE_R_TYPE_OP);
  assign i_type  = (aluop_i == EXE_I_TYPE_OP);
  assign base_op = i_type || (r_type && ((alufunct7_i == F7_BASE) || (alufunct7_i == F7_ALT)));
  assign mul_op  = r_type && (alufunct7_i == F7_MULDIV) && !alufunct3_i[2];
  assign div_op  = is_div_op(aluop_i, alufunct3_i, alufunct7_i);
  // I-type funct7 bits are immediate bits, so only R-type may select SUB
  assign is_sub  = r_type && alufunct7_i[5];
  assign shamt   = reg2_i[4:0];
  assign slt_res = $signed(reg1_i) < $signed(reg2_i);
  assign sra_res = $signed(reg1_i) >>> shamt;

  // 33x33 signed product covers all four MUL variants
  assign a_signed    = (alufunct3_i != F3_MULHU);
  assign b_signed    = (alufunct3_i == F3_MUL) || (alufunct3_i == F3_MULH);
  assign mul_a       = {a_signed & reg1_i[RegBus-1], reg1_i};
  assign mul_b       = {b_signed & reg2_i[RegBus-1], reg2_i};
  assign prod        = ProdW'(mul_a) * ProdW'(mul_b);
  assign unused_prod = ^prod[ProdW-1:2*RegBus];

  always_comb begin
    alu_res = '0;
    if (base_op) begin
      case (alufunct3_i)
        F3_ADD:  alu_res = is_sub ? (reg1_i - reg2_i) : (reg1_i + reg2_i);
        F3_SLL:  alu_res = reg1_i << shamt;
        F3_SLT:  alu_res = RegBus'(slt_res);
        F3_SLTU: alu_res = RegBus'(reg1_i < reg2_i);
        F3_XOR:  alu_res = reg1_i ^ reg2_i;
        F3_SR:   alu_res = alufunct7_i[5] ? sra_res : (reg1_i >> shamt);
        F3_OR:   alu_res = reg1_i | reg2_i;
        F3_AND:  alu_res = reg1_i & reg2_i;
        default: alu_res = '0;
      endcase
    end else if (mul_op) begin
      alu_res = (alufunct3_i == F3_MUL) ? prod[RegBus-1:0] : prod[2*RegBus-1:RegBus];
    end
  end

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op),
    .signed_op (!alufunct3_i[0]),
    .rem_op    (alufunct3_i[1]),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .flush     (flush),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Writeback triple; a stall or flush turns this slot into a bubble
  always_comb begin
    wb       = '0;
    stallreq = 1'b0;
    if (!rst) begin
      stallreq = div_busy;
      wb.wd    = wd_i && !flush && !div_busy;
      wb.wreg  = wreg_i;
      wb.wdata = div_op ? (div_done ? div_result : '0) : alu_res;
    end
  end

  assign wd_o    = wb.wd;
  assign wreg_o  = wb.wreg;
  assign wdata_o = wb.wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: arithmetic reference model plus a
// cycle-level stall/latency model, with hand-computed directed vectors.
module tb_ex_stage;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  aluop;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wreg;
  logic        wd;
  logic        flush;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  int n_cmp = 0;
  int n_err = 0;
  int age   = 0;

  logic        exp_stall;
  logic        exp_wd;
  logic [31:0] exp_data;
  logic        in_div;

  logic [31:0] vals [6];
  logic [6:0]  f7s  [3];

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .alufunct3_i (f3),
    .alufunct7_i (f7),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .wreg_i      (wreg),
    .wd_i        (wd),
    .flush       (flush),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq    (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_div(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7);
    return (op == OP_R) && (fn7 == 7'b0000001) && fn3[2];
  endfunction

  function automatic logic [31:0] div_model(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return fn3[1] ? a : 32'hFFFF_FFFF;
    if (!fn3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return fn3[1] ? 32'h0 : 32'h8000_0000;
    case (fn3[1:0])
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Stall cycles before the divide result appears
  function automatic int div_lat(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!fn3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                                            input logic [31:0] a, input logic [31:0] b);
    int                sa;
    int                sb;
    longint            p;
    longint unsigned   pu;
    logic [4:0]        sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    if (op == OP_I || (op == OP_R && (fn7 == 7'h00 || fn7 == 7'h20))) begin
      case (fn3)
        3'd0:    return (op == OP_R && fn7[5]) ? a - b : a + b;
        3'd1:    return a << sh;
        3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
        3'd3:    return (a < b) ? 32'd1 : 32'd0;
        3'd4:    return a ^ b;
        3'd5:    return fn7[5] ? 32'(sa >>> sh) : a >> sh;
        3'd6:    return a | b;
        default: return a & b;
      endcase
    end
    if (op == OP_R && fn7 == 7'h01) begin
      case (fn3)
        3'd0: begin p = longint'(sa) * longint'(sb); return 32'(p); end
        3'd1: begin p = longint'(sa) * longint'(sb); return 32'(p >>> 32); end
        3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return 32'(p >>> 32); end
        3'd3: begin pu = {32'h0, a} * {32'h0, b}; return 32'(pu >> 32); end
        default: return div_model(fn3, a, b);
      endcase
    end
    return 32'h0;
  endfunction

  // How many cycles the current divide has sat in EX
  always @(posedge clk) begin
    if (rst || flush || !is_div(aluop, f3, f7)) age <= 0;
    else if (age >= div_lat(f3, reg1, reg2)) age <= 0;
    else age <= age + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_wd", 32'(wd_o), 32'h0);
      check("rst_wreg", 32'(wreg_o), 32'h0);
      check("rst_wdata", wdata_o, 32'h0);
      check("rst_stall", 32'(stallreq), 32'h0);
    end else begin
      in_div    = is_div(aluop, f3, f7);
      exp_stall = in_div && !flush && (age < div_lat(f3, reg1, reg2));
      exp_wd    = wd && !flush && !exp_stall;
      exp_data  = alu_model(aluop, f3, f7, reg1, reg2);
      check("stallreq", 32'(stallreq), 32'(exp_stall));
      check("wd_o", 32'(wd_o), 32'(exp_wd));
      check("wreg_o", 32'(wreg_o), 32'(wreg));
      if (!exp_stall && !flush) check("wdata_o", wdata_o, exp_data);
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic we);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    flush = 1'b0;
    aluop = op;
    f3    = fn3;
    f7    = fn7;
    reg1  = a;
    reg2  = b;
    wreg  = rd;
    wd    = we;
  endtask

  // Count stall cycles of the divide just driven, then check its result
  task automatic wait_div(input string nm, input int exp_stalls, input logic [31:0] exp_val);
    int  n   = 0;
    bit  fin = 0;
    int  guard = 0;
    while (!fin && guard < 60) begin
      @(negedge clk);
      #1;
      if (stallreq) begin
        n++;
        if (wd_o) check({nm, "_wd_in_stall"}, 32'(wd_o), 32'h0);
      end else fin = 1;
      guard++;
    end
    if (!fin) check({nm, "_timeout"}, 32'(fin), 32'h1);
    check({nm, "_stalls"}, 32'(n), 32'(exp_stalls));
    check({nm, "_wdata"}, wdata_o, exp_val);
    check({nm, "_wd"}, 32'(wd_o), 32'h1);
  endtask

  task automatic expect_now(input string nm, input logic [31:0] exp_val);
    @(negedge clk);
    #1;
    check({nm, "_wdata"}, wdata_o, exp_val);
    check({nm, "_stall"}, 32'(stallreq), 32'h0);
  endtask

  initial begin
    vals[0] = 32'h0000_0000; vals[1] = 32'h0000_0001; vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'hFFFF_FFFF; vals[5] = 32'h1234_5678;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;

    rst = 1'b1; flush = 1'b0; aluop = OP_R; f3 = 3'd0; f7 = 7'h00;
    reg1 = 32'd9; reg2 = 32'd4; wreg = 5'd3; wd = 1'b1;
    repeat (3) @(posedge clk);

    drive(OP_I, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
    @(negedge clk);
    #1;
    check("addi_wdata", wdata_o, 32'h8000_0000);
    check("addi_wreg", 32'(wreg_o), 32'd5);
    check("addi_wd", 32'(wd_o), 32'h1);
    check("addi_stall", 32'(stallreq), 32'h0);

    drive(OP_R, 3'd0, 7'h20, 32'd3, 32'd5, 5'd6, 1'b1);
    expect_now("sub", 32'hFFFF_FFFE);
    drive(OP_I, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 5'd7, 1'b1);
    expect_now("srai", 32'hF800_0000);
    drive(OP_R, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF, 5'd8, 1'b1);
    expect_now("sltu", 32'h1);
    drive(OP_R, 3'd2, 7'h00, 32'd1, 32'hFFFF_FFFF, 5'd8, 1'b1);
    expect_now("slt", 32'h0);
    drive(OP_R, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1);
    expect_now("mulh", 32'h4000_0000);
    drive(OP_R, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    expect_now("mulhu", 32'hFFFF_FFFE);
    drive(OP_R, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    expect_now("mulhsu", 32'hFFFF_FFFF);
    drive(7'b0110111, 3'd0, 7'h00, 32'd5, 32'd6, 5'd10, 1'b1);
    expect_now("other_op", 32'h0);

    // Sweep of single-cycle ops, checked by the model
    for (int op = 0; op < 2; op++)
      for (int fi = 0; fi < 3; fi++)
        for (int fn = 0; fn < 8; fn++)
          for (int k = 0; k < 6; k++) begin
            if (op == 0 && fi == 2) continue;
            if (fi == 2 && fn >= 4) continue;
            drive(op == 0 ? OP_I : OP_R, 3'(fn), f7s[fi], vals[k], vals[(k + 3) % 6], 5'(k + 1), 1'b1);
          end

    drive(OP_R, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
    wait_div("div_m7_2", 33, 32'hFFFF_FFFD);
    drive(OP_R, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
    wait_div("rem_m7_2", 33, 32'hFFFF_FFFF);
    drive(OP_R, 3'd4, 7'h01, 32'd100, 32'hFFFF_FFF9, 5'd12, 1'b1);
    wait_div("div_100_m7", 33, 32'hFFFF_FFF2);
    drive(OP_R, 3'd7, 7'h01, 32'hFFFF_FFFF, 32'd10, 5'd12, 1'b1);
    wait_div("remu_big", 33, 32'd5);
    drive(OP_R, 3'd5, 7'h01, 32'd1234, 32'd0, 5'd13, 1'b1);
    wait_div("divu_zero", 1, 32'hFFFF_FFFF);
    drive(OP_R, 3'd6, 7'h01, 32'hFFFF_FF00, 32'd0, 5'd13, 1'b1);
    wait_div("rem_zero", 1, 32'hFFFF_FF00);
    drive(OP_R, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    wait_div("div_ovf", 1, 32'h8000_0000);
    drive(OP_R, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
    wait_div("rem_ovf", 1, 32'h0);

    // Flush a divide in the middle of its iterations
    drive(OP_R, 3'd4, 7'h01, 32'd100, 32'd3, 5'd15, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    check("flush_pre_stall", 32'(stallreq), 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_stall", 32'(stallreq), 32'h0);
    check("flush_wd", 32'(wd_o), 32'h0);
    drive(OP_R, 3'd0, 7'h00, 32'd2, 32'd3, 5'd16, 1'b1);
    expect_now("add_after_flush", 32'd5);
    @(negedge clk);
    #1;
    check("add_after_flush_wd", 32'(wd_o), 32'h1);

    // Reset in the middle of a divide, then the same divide restarts cleanly
    drive(OP_R, 3'd4, 7'h01, 32'd1000, 32'd7, 5'd17, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_wd", 32'(wd_o), 32'h0);
    check("rst_mid_wdata", wdata_o, 32'h0);
    check("rst_mid_stall", 32'(stallreq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_div("div_after_rst", 33, 32'd142);

    drive(OP_R, 3'd0, 7'h00, 32'd40, 32'd2, 5'd18, 1'b0);
    expect_now("add_wd0", 32'd42);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline.
- Consumes the decoded operands held in id_ex and produces the writeback triple (wd, wreg, wdata) for ex_mem.
- Computes ALU and MUL results in one cycle.
- Runs DIV/DIVU/REM/REMU on an iterative radix-2 divider and asserts stallreq to the pipeline controller while the divider is busy.

Parameters:
- None. Widths come from the shared define file (RegBus = 32, RegAddrBus = 5, AluOpBus = 7, AluFunct3Bus = 3).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1).
- aluop_i  in  7  opcode field from id_ex.
- alufunct3_i  in  3  funct3 from id_ex.
- alufunct7_i  in  7  funct7 from id_ex. id_ex gains this field in the same change.
- reg1_i  in  32  operand 1 (rs1 value).
- reg2_i  in  32  operand 2 (rs2 value or sign-extended immediate).
- wreg_i  in  5  destination register address.
- wd_i  in  1  write enable.
- flush  in  1  annul the instruction currently in EX (branch redirect).
- wd_o  out  1  write enable to ex_mem.
- wreg_o  out  5  destination address to ex_mem.
- wdata_o  out  32  result.
- stallreq  out  1  hold PC, if_id and id_ex this cycle.

Behaviour:
- Outputs are combinational from the inputs and divider state. While rst = 1 all outputs are 0 and the divider FSM is forced to IDLE.
- I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI. SRAI is selected by alufunct7_i[5]; shift amount is reg2_i[4:0].
- R-type (0110011) with funct7 = 0000000 or 0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
- R-type with funct7 = 0000001 (M extension):
  - MUL, MULH, MULHSU, MULHU use a combinational 33x33 signed product and complete in one cycle.
  - funct3 1xx (DIV, DIVU, REM, REMU) goes to the divider.
- Any other aluop: wdata_o = 0; wd_o and wreg_o pass through.
- Arithmetic wraps modulo 2^32. SLT is signed; SLTU is unsigned.
- Divider FSM states: IDLE, CALC, DONE.
- IDLE, non-div op: stallreq = 0.
- IDLE, div op and flush = 0:
  - stallreq = 1.
  - If divisor == 0 or signed overflow (0x80000000 / -1): latch the special result, go to DONE.
  - Otherwise latch |dividend|, |divisor|, result sign and quotient/remainder select; clear cnt; go to CALC.
- CALC: one restoring-subtract step per cycle; stallreq = 1; cnt increments. After the cycle with cnt = 31, go to DONE.
- DONE: stallreq = 0; wdata_o = sign-corrected result from registers; wd_o = wd_i. Next state is IDLE. The pipeline advances on this edge, so the same instruction is never restarted.
- Latency:
  - Normal divide: stallreq high for 33 cycles (1 in IDLE + 32 in CALC); result valid in cycle 34.
  - Special case: stallreq high for 1 cycle; result valid in cycle 2.
- While stallreq = 1, wd_o = 0 so ex_mem captures a bubble.
- Special results:
  - Division by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - Overflow: DIV = 0x80000000; REM = 0.
- Signs: quotient is negated when operand signs differ (signed ops); remainder takes the sign of the dividend.
- flush = 1 in any state:
  - Next state is IDLE and cnt is cleared.
  - stallreq = 0 and wd_o = 0 in that cycle.
- rst has priority over flush.
- The divider ignores inputs in CALC and DONE; id_ex is held stable by the stall.

Decomposition:
- Shared define file gains:
  - opcode constants EXE_R_TYPE_OP and EXE_I_TYPE_OP.
  - funct3 constants for all ALU and M operations.
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
  - divider state encodings DIV_IDLE, DIV_CALC, DIV_DONE.
- One sub-module: ex_div. It holds the FSM, operand registers, the 5-bit counter and the special-case logic. Interface: start, signed_op, rem_op, dividend, divisor, flush, busy, done, result.
- ALU and multiplier stay in ex_stage.

Test Plan:
- ADDI reg1 = 0x7FFFFFFF, reg2 = 1, wreg = 5, wd = 1 -> same cycle wdata_o = 0x80000000, wreg_o = 5, wd_o = 1, stallreq = 0.
- SUB (funct7 0100000) 3 - 5 -> 0xFFFFFFFE; SRAI 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE, single cycle.
- DIV -7 / 2 -> stallreq high exactly 33 cycles, wd_o = 0 throughout; cycle 34 wdata_o = 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU x / 0 -> 0xFFFFFFFF after 1 stall cycle. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same overflow case -> 0.
- DIV started, then flush at CALC cycle 10 -> stallreq = 0 and wd_o = 0 that cycle, FSM back in IDLE. A following ADD completes normally. Separately, rst asserted mid-CALC -> all outputs 0 and the FSM is in IDLE on the next edge.
